mult_arbiter: RTL

//  Round-robin arbiter and sequencer sharing one multiplier core between two requesters
//  (SPI front-end on port 0, local requester on port 1).
//  - Grants one requester, latches its operands and pulses the multiplier start.
//  - Waits for the multiplier's done, captures the product and returns it with a one-cycle valid.
//  - Sits between the SPI control FSM / local logic and the multiplier datapath.

---
 rtl/mult_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multiplier between two requesters.
// Optional BUSY timeout abort enabled by defining MULT_TIMEOUT_EN.
module mult_arbiter #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               grant0,
   output logic               grant1,
   output logic               res_valid0,
   output logic               res_valid1,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic [WIDTH-1:0]   mult_a,
   output logic [WIDTH-1:0]   mult_b,
   output logic               mult_start,
   input  logic               mult_done,
   input  logic [2*WIDTH-1:0] mult_result
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RETIRE} state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic               owner_q, owner_d;
   logic [WIDTH-1:0]   mult_a_q, mult_a_d;
   logic [WIDTH-1:0]   mult_b_q, mult_b_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               grant0_q, grant0_d;
   logic               grant1_q, grant1_d;
   logic               rv0_q, rv0_d;
   logic               rv1_q, rv1_d;
   logic               start_q, start_d;
   logic               win;

`ifdef MULT_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CW-1:0] ctr_q, ctr_d;
   logic          err_q, err_d;
`endif

   // Next-state and next-output decode; outputs leave straight from flops.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      owner_d  = owner_q;
      mult_a_d = mult_a_q;
      mult_b_d = mult_b_q;
      result_d = result_q;
      grant0_d = 1'b0;
      grant1_d = 1'b0;
      rv0_d    = 1'b0;
      rv1_d    = 1'b0;
      start_d  = 1'b0;
      win      = 1'b0;
`ifdef MULT_TIMEOUT_EN
      ctr_d    = ctr_q;
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the port that was not served last wins.
               win      = (req0 && req1) ? ~last_q : req1;
               owner_d  = win;
               mult_a_d = win ? a1 : a0;
               mult_b_d = win ? b1 : b0;
               grant0_d = ~win;
               grant1_d = win;
               start_d  = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            state_d = BUSY;
`ifdef MULT_TIMEOUT_EN
            ctr_d   = '0;
`endif
         end
         BUSY: begin
            if (mult_done) begin
               result_d = mult_result;
               rv0_d    = ~owner_q;
               rv1_d    = owner_q;
               state_d  = RETIRE;
`ifdef MULT_TIMEOUT_EN
               err_d    = 1'b0;
            end else if (ctr_q == CW'(TIMEOUT-1)) begin
               result_d = '0;
               err_d    = 1'b1;
               rv0_d    = ~owner_q;
               rv1_d    = owner_q;
               state_d  = RETIRE;
            end else begin
               ctr_d    = ctr_q + 1'b1;
`endif
            end
         end
         RETIRE: begin
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         mult_a_q <= '0;
         mult_b_q <= '0;
         result_q <= '0;
         grant0_q <= 1'b0;
         grant1_q <= 1'b0;
         rv0_q    <= 1'b0;
         rv1_q    <= 1'b0;
         start_q  <= 1'b0;
`ifdef MULT_TIMEOUT_EN
         ctr_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         mult_a_q <= mult_a_d;
         mult_b_q <= mult_b_d;
         result_q <= result_d;
         grant0_q <= grant0_d;
         grant1_q <= grant1_d;
         rv0_q    <= rv0_d;
         rv1_q    <= rv1_d;
         start_q  <= start_d;
`ifdef MULT_TIMEOUT_EN
         ctr_q    <= ctr_d;
         err_q    <= err_d;
`endif
      end
   end

   assign grant0     = grant0_q;
   assign grant1     = grant1_q;
   assign res_valid0 = rv0_q;
   assign res_valid1 = rv1_q;
   assign result     = result_q;
   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign mult_start = start_q;
`ifdef MULT_TIMEOUT_EN
   assign err        = err_q;
`else
   assign err        = 1'b0;
`endif

endmodule
